// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
// Frame on the wire: SYNC, ADDR, CMD, D3, D2, D1, D0, CHK with CHK = XOR of ADDR..D0.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_ADDR = 3'd1,
        ST_CMD  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_e;

    localparam int         FRAME_DATA_BYTES = 4;
    localparam logic [7:0] DEFAULT_SYNC     = 8'hA5;
    localparam logic [7:0] DEFAULT_DEV      = 8'h01;
    localparam logic [7:0] DEFAULT_BCAST    = 8'hFF;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  code;
        logic [31:0] data;
    } cmd_t;

    function automatic logic addr_accepted(input logic [7:0] addr,
                                           input logic [7:0] dev,
                                           input logic [7:0] bcast);
        return (addr == dev) || (addr == bcast);
    endfunction

endpackage

// File: rtl/uart_cmd_holdreg.sv
// Single-entry output register for decoded commands, with an overflow pulse
// when a new command arrives while the previous one is still unaccepted.
module uart_cmd_holdreg
    import uart_cmd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  cmd_t i_cmd,
    input  logic i_ready,
    output logic o_valid,
    output cmd_t o_cmd,
    output logic o_ovf
);

    // Handshake: a command transfers on any cycle where o_valid and i_ready are
    // both high; o_cmd is stable while o_valid waits, and holds after transfer.
    // A load in the transfer cycle replaces the outgoing entry without a gap.
    logic r_valid;
    cmd_t r_cmd;
    logic r_ovf;
    logic w_accept;
    logic w_slot_free;

    assign w_accept    = r_valid & i_ready;
    assign w_slot_free = ~r_valid | w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_cmd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (i_load && w_slot_free) begin
                r_valid <= 1'b1;
                r_cmd   <= i_cmd;
            end else if (i_load) begin
                r_ovf <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_cmd   = r_cmd;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Sync-hunting frame assembler: checks XOR checksum and device address, then
// hands accepted commands to the motor sequencer through a valid/ready register.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC,
    parameter logic [7:0] DEV_ADDR   = DEFAULT_DEV,
    parameter logic [7:0] BCAST_ADDR = DEFAULT_BCAST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_eop,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_data,
    output logic        err_chk,
    output logic        err_ovf,
    output logic        err_timeout,
    output logic        busy,
    output state_e      dbg_state
);

    localparam logic [1:0] LAST_DATA_IDX = 2'(FRAME_DATA_BYTES - 1);

    state_e     r_state;
    logic [1:0] r_byte_cnt;
    logic [7:0] r_acc;
    cmd_t       r_shadow;
    logic       r_err_chk;
    logic       r_err_timeout;
    logic       r_busy;

    state_e     w_state_nx;
    logic [1:0] w_cnt_nx;
    logic [7:0] w_acc_nx;
    cmd_t       w_shadow_nx;
    logic       w_commit;
    logic       w_err_chk_nx;
    logic       w_err_timeout_nx;
    cmd_t       w_out_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_byte_cnt    <= 2'd0;
            r_acc         <= 8'h00;
            r_shadow      <= '0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_byte_cnt    <= w_cnt_nx;
            r_acc         <= w_acc_nx;
            r_shadow      <= w_shadow_nx;
            r_err_chk     <= w_err_chk_nx;
            r_err_timeout <= w_err_timeout_nx;
            r_busy        <= (w_state_nx != ST_HUNT);
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_byte_cnt;
        w_acc_nx         = r_acc;
        w_shadow_nx      = r_shadow;
        w_commit         = 1'b0;
        w_err_chk_nx     = 1'b0;
        w_err_timeout_nx = 1'b0;

        // End-of-packet mid-frame takes priority over a coincident byte.
        if (rx_eop && (r_state != ST_HUNT)) begin
            w_state_nx       = ST_HUNT;
            w_cnt_nx         = 2'd0;
            w_shadow_nx      = '0;
            w_err_timeout_nx = 1'b1;
        end else if (rx_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (rx_data == SYNC_BYTE) begin
                        w_state_nx = ST_ADDR;
                        w_acc_nx   = 8'h00;
                        w_cnt_nx   = 2'd0;
                    end
                end
                ST_ADDR: begin
                    w_shadow_nx.addr = rx_data;
                    w_acc_nx         = r_acc ^ rx_data;
                    w_state_nx       = ST_CMD;
                end
                ST_CMD: begin
                    w_shadow_nx.code = rx_data;
                    w_acc_nx         = r_acc ^ rx_data;
                    w_cnt_nx         = 2'd0;
                    w_state_nx       = ST_DATA;
                end
                ST_DATA: begin
                    w_shadow_nx.data = {r_shadow.data[23:0], rx_data};
                    w_acc_nx         = r_acc ^ rx_data;
                    if (r_byte_cnt == LAST_DATA_IDX) begin
                        w_cnt_nx   = 2'd0;
                        w_state_nx = ST_CHK;
                    end else begin
                        w_cnt_nx = r_byte_cnt + 2'd1;
                    end
                end
                ST_CHK: begin
                    w_state_nx = ST_HUNT;
                    if (rx_data != r_acc) begin
                        w_err_chk_nx = 1'b1;
                    end else if (addr_accepted(r_shadow.addr, DEV_ADDR, BCAST_ADDR)) begin
                        w_commit = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_HUNT;
                end
            endcase
        end
    end

    uart_cmd_holdreg u_holdreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_commit),
        .i_cmd   (r_shadow),
        .i_ready (cmd_ready),
        .o_valid (cmd_valid),
        .o_cmd   (w_out_cmd),
        .o_ovf   (err_ovf)
    );

    assign cmd_addr    = w_out_cmd.addr;
    assign cmd_code    = w_out_cmd.code;
    assign cmd_data    = w_out_cmd.data;
    assign err_chk     = r_err_chk;
    assign err_timeout = r_err_timeout;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: expected output events are queued by the
// stimulus and popped by a negedge monitor; direct checks cover static state.
module tb_uart_cmd_decoder;
    import uart_cmd_pkg::*;

    localparam int W = 50;
    localparam logic [1:0] K_CMD = 2'd0;
    localparam logic [1:0] K_CHK = 2'd1;
    localparam logic [1:0] K_OVF = 2'd2;
    localparam logic [1:0] K_TO  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_eop;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        err_chk;
    logic        err_ovf;
    logic        err_timeout;
    logic        busy;
    state_e      dbg_state;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    uart_cmd_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_eop      (rx_eop),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_code    (cmd_code),
        .cmd_data    (cmd_data),
        .err_chk     (err_chk),
        .err_ovf     (err_ovf),
        .err_timeout (err_timeout),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard helpers
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic exp_cmd(input logic [7:0] a, input logic [7:0] c, input logic [31:0] d);
        exp_q.push_back({K_CMD, a, c, d});
    endtask

    task automatic exp_err(input logic [1:0] k);
        exp_q.push_back({k, 48'h0});
    endtask

    task automatic pop_event(input string name, input logic [W-1:0] got);
        logic [W-1:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event %0h, expected none", name, got);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                n_fail++;
                $display("FAIL %s: got event %0h expected %0h", name, got, e);
            end
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (cmd_valid && (!prev_valid || prev_hs))
                pop_event("cmd", {K_CMD, cmd_addr, cmd_code, cmd_data});
            if (err_chk)     pop_event("err_chk", {K_CHK, 48'h0});
            if (err_ovf)     pop_event("err_ovf", {K_OVF, 48'h0});
            if (err_timeout) pop_event("err_timeout", {K_TO, 48'h0});
            prev_valid = cmd_valid;
            prev_hs    = cmd_valid & cmd_ready;
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_eop();
        rx_eop = 1'b1;
        @(posedge clk);
        #1;
        rx_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c,
                              input logic [31:0] d, input logic [7:0] chk,
                              input logic ready_on_chk);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(c);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
        if (ready_on_chk) cmd_ready = 1'b1;
        send_byte(chk);
        if (ready_on_chk) cmd_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " cmd_valid"},   64'(cmd_valid),   64'h0);
        check({tag, " cmd_addr"},    64'(cmd_addr),    64'h0);
        check({tag, " cmd_code"},    64'(cmd_code),    64'h0);
        check({tag, " cmd_data"},    64'(cmd_data),    64'h0);
        check({tag, " err_chk"},     64'(err_chk),     64'h0);
        check({tag, " err_ovf"},     64'(err_ovf),     64'h0);
        check({tag, " err_timeout"}, 64'(err_timeout), 64'h0);
        check({tag, " busy"},        64'(busy),        64'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        rx_eop    = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(2);

        // good frame, consumer ready
        cmd_ready = 1'b1;
        exp_cmd(8'h01, 8'h10, 32'h0000_01F4);
        send_frame(8'h01, 8'h10, 32'h0000_01F4, 8'hE4, 1'b0);
        check("busy after chk", 64'(busy), 64'h0);
        idle(1);
        check("valid cleared after hs", 64'(cmd_valid), 64'h0);
        check("data holds after hs", 64'(cmd_data), 64'h1F4);

        // checksum error
        exp_err(K_CHK);
        send_frame(8'h01, 8'h10, 32'h0000_01F4, 8'hE5, 1'b0);
        check("busy after bad chk", 64'(busy), 64'h0);
        idle(1);
        check("no valid on bad chk", 64'(cmd_valid), 64'h0);

        // broadcast accepted, foreign address silently dropped
        exp_cmd(8'hFF, 8'h10, 32'h0000_01F4);
        send_frame(8'hFF, 8'h10, 32'h0000_01F4, 8'h1A, 1'b0);
        idle(2);
        send_frame(8'h02, 8'h10, 32'h0000_01F4, 8'hE7, 1'b0);
        idle(2);
        check("foreign addr no valid", 64'(cmd_valid), 64'h0);
        check("foreign addr data kept", 64'(cmd_addr), 64'hFF);

        // junk, partial frame, eop abort, then a good frame
        send_byte(8'h33);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        check("busy mid frame", 64'(busy), 64'h1);
        exp_err(K_TO);
        send_eop();
        check("busy after eop", 64'(busy), 64'h0);
        send_eop();
        exp_cmd(8'h01, 8'h10, 32'h0000_01F4);
        send_frame(8'h01, 8'h10, 32'h0000_01F4, 8'hE4, 1'b0);
        idle(2);

        // overflow while output occupied
        cmd_ready = 1'b0;
        exp_cmd(8'h01, 8'h10, 32'h0000_01F4);
        send_frame(8'h01, 8'h10, 32'h0000_01F4, 8'hE4, 1'b0);
        exp_err(K_OVF);
        send_frame(8'h01, 8'h10, 32'h0000_002A, 8'h3B, 1'b0);
        check("ovf valid held", 64'(cmd_valid), 64'h1);
        check("ovf data kept", 64'(cmd_data), 64'h1F4);
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        check("valid clears after ready", 64'(cmd_valid), 64'h0);

        // ready pulsed on the second CHK cycle: replace without overflow
        exp_cmd(8'h01, 8'h10, 32'h0000_01F4);
        send_frame(8'h01, 8'h10, 32'h0000_01F4, 8'hE4, 1'b0);
        exp_cmd(8'h01, 8'h10, 32'h0000_002A);
        send_frame(8'h01, 8'h10, 32'h0000_002A, 8'h3B, 1'b1);
        check("replace valid stays", 64'(cmd_valid), 64'h1);
        check("replace data", 64'(cmd_data), 64'h2A);
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        check("replace drained", 64'(cmd_valid), 64'h0);

        // sync value inside the body is plain data; left pending
        exp_cmd(8'h01, 8'h10, 32'h00A5_0000);
        send_frame(8'h01, 8'h10, 32'h00A5_0000, 8'hB4, 1'b0);
        check("body sync pending", 64'(cmd_valid), 64'h1);

        // reset in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        cmd_ready = 1'b1;
        exp_cmd(8'h01, 8'h10, 32'h0000_01F4);
        send_frame(8'h01, 8'h10, 32'h0000_01F4, 8'hE4, 1'b0);
        idle(3);

        check("pending expected events", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
